sram_bank: RTL and testbench
============================

Name: sram_bank

Overview:
Parametrised single-port synchronous SRAM bank with a valid/ready request channel, per-byte write enables and a one-cycle registered read response. After reset it clears its contents in hardware, sweeping one word per cycle, instead of clearing the whole array at once. A soft-clear input re-runs that sweep without a reset. Used as instruction and data memory behind the CPU load/store and fetch units.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 8
ADDR_W, 14, word address width; DEPTH = 2**ADDR_W words
INIT_VAL, 0, value (DATA_W bits) written to every word during the init sweep

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  asynchronous, active-low reset
soft_clear  input  1  single-cycle pulse; restarts the init sweep; honoured only in RUN
req_valid  input  1  request present
req_ready  output  1  bank can accept a request this cycle
req_we  input  1  1 = write, 0 = read
req_be  input  DATA_W/8  byte write enables; ignored for reads
req_addr  input  ADDR_W  word address
req_wdata  input  DATA_W  write data
rsp_valid  output  1  rsp_rdata is valid this cycle
rsp_rdata  output  DATA_W  read data
init_busy  output  1  init sweep in progress

Behaviour:
- While rst = 0: state = INIT, init counter = 0, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, init_busy = 1.
- FSM has two states, INIT and RUN.
- INIT:
  - Each cycle writes INIT_VAL to mem[counter], then increments counter.
  - When counter = DEPTH-1, that word is written and the next state is RUN.
  - The sweep takes exactly DEPTH cycles.
  - req_ready = 0 and init_busy = 1 for the whole sweep.
- RUN:
  - req_ready = 1 and init_busy = 0.
  - A request is accepted when req_valid & req_ready.
  - Accepted write: for each byte b with req_be[b] = 1, mem[addr] byte b <= req_wdata byte b. Other bytes keep their value. No response is generated.
  - Accepted write with req_be = 0: no memory change and no error.
  - Accepted read: on the next cycle rsp_valid = 1 and rsp_rdata = mem[addr] as it was before this edge.
  - Back-to-back reads give one response per cycle, in order.
  - A read after a write to the same address on the following cycle returns the new data.
- rsp_valid is 0 in every cycle not following an accepted read.
- rsp_rdata holds its last value when rsp_valid = 0.
- soft_clear in RUN:
  - If a request is also accepted in that same cycle, it completes first. A write is performed; a read still produces its response on the next cycle.
  - State then goes to INIT with counter = 0.
- soft_clear is ignored in INIT.
- Reset asserted mid-sweep or mid-operation: state is forced to INIT and counter to 0 asynchronously. Array contents are undefined until the new sweep finishes. No partial responses.
- The address range is the full 2**ADDR_W, so no out-of-range case exists.

Optional Feature:
Macro SRAM_PARITY_EN.
- When defined:
  - The array stores one even-parity bit per byte alongside the data, written on every byte write and on init.
  - Extra output port parity_err (1 bit) is valid with rsp_valid; it is 1 if any byte of the read word fails parity.
  - parity_err resets to 0 and is 0 whenever rsp_valid = 0.
  - Adds a hidden test input inj_err (1 bit). When 1 on an accepted write, the stored parity of byte 0 is inverted.
- When undefined: no parity storage, no parity_err or inj_err ports, and all other behaviour is identical.

Test Plan:
- Init: release rst with ADDR_W=4. init_busy stays 1 and req_ready stays 0 for exactly 16 cycles, then RUN. Reads of addresses 0..15 each return 0x00000000.
- Write/read: write 0xDEADBEEF to addr 5 with req_be=4'hF, then read addr 5 on the next cycle -> rsp_valid=1 and rsp_rdata=0xDEADBEEF one cycle after the read is accepted.
- Byte enables: word holds 0xDEADBEEF; write 0x11223344 with req_be=4'b0101 -> a later read returns 0xDE22BE44.
- Pipelined reads: reads to addr 1, 2, 3 in consecutive cycles -> three consecutive rsp_valid pulses with the matching data, in order. A write in between produces no rsp_valid.
- Soft clear and reset mid-sweep: soft_clear together with a write 0x5 to addr 3 -> the write lands, then 16 init cycles, then a read of addr 3 returns 0. Asserting rst at sweep cycle 7 restarts the full 16-cycle sweep.
- Parity (SRAM_PARITY_EN): write 0xA5A5A5A5 with inj_err=1, then read -> parity_err=1. Rewrite with inj_err=0, then read -> parity_err=0.

Source files
------------

// File: rtl/sram_bank.sv
// ============================================================================
// Module   : sram_bank
// Brief    : Single-port SRAM bank, valid/ready requests, byte enables,
//            registered read, hardware init sweep. Optional: SRAM_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_bank #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 14,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  soft_clear,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DATA_W/8-1:0]   req_be,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
`ifdef SRAM_PARITY_EN
  input  logic                  inj_err,
  output logic                  parity_err,
`endif
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  init_busy
);

  localparam int c_NB    = DATA_W / 8;
  localparam int c_DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt, w_cnt_nxt;

  logic                w_acc, w_wr, w_rd;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [c_NB-1:0]     w_mem_be;
  logic [DATA_W-1:0]   w_mem_wdata;
  logic [DATA_W-1:0]   w_rd_word;

  logic [DATA_W-1:0]   r_mem [c_DEPTH];
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    req_ready   = 1'b0;
    init_busy   = 1'b1;
    case (r_state)
      ST_INIT: begin
        // Counter wraps to zero on the last word, leaving it ready for the next sweep
        w_cnt_nxt = r_cnt + ADDR_W'(1);
        if (r_cnt == {ADDR_W{1'b1}}) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        req_ready = 1'b1;
        init_busy = 1'b0;
        if (soft_clear) begin
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign w_acc = req_valid & req_ready;
  assign w_wr  = w_acc & req_we;
  assign w_rd  = w_acc & ~req_we;

  // Single write port shared by the init sweep and accepted writes
  assign w_mem_we    = init_busy | w_wr;
  assign w_mem_addr  = init_busy ? r_cnt    : req_addr;
  assign w_mem_be    = init_busy ? '1       : req_be;
  assign w_mem_wdata = init_busy ? INIT_VAL : req_wdata;
  assign w_rd_word   = r_mem[req_addr];

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < c_NB; b++) begin
        if (w_mem_be[b]) r_mem[w_mem_addr][b*8 +: 8] <= w_mem_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_rd;
      if (w_rd) r_rsp_rdata <= w_rd_word;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

`ifdef SRAM_PARITY_EN
  logic [c_NB-1:0] r_par [c_DEPTH];
  logic [c_NB-1:0] w_wpar;
  logic [c_NB-1:0] w_rd_par;
  logic [c_NB-1:0] w_rd_bad;
  logic [c_NB-1:0] w_inj;
  logic            r_perr;

  generate
    for (genvar gb = 0; gb < c_NB; gb++) begin : g_par
      assign w_wpar[gb]   = ^w_mem_wdata[gb*8 +: 8];
      assign w_rd_bad[gb] = ^{w_rd_word[gb*8 +: 8], w_rd_par[gb]};
    end
  endgenerate

  // Error injection flips only the byte-0 check bit of a user write
  assign w_inj    = c_NB'(w_wr & inj_err);
  assign w_rd_par = r_par[req_addr];

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < c_NB; b++) begin
        if (w_mem_be[b]) r_par[w_mem_addr][b] <= w_wpar[b] ^ w_inj[b];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_perr <= 1'b0;
    else      r_perr <= w_rd & (|w_rd_bad);
  end

  assign parity_err = r_perr;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_bank.sv
// Scoreboard bench for sram_bank (ADDR_W=4); build with SRAM_PARITY_EN for the parity cases.
`default_nettype none

module tb_sram_bank;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          soft_clear = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [3:0]    req_be = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          init_busy;
`ifdef SRAM_PARITY_EN
  logic          inj_err = 1'b0;
  logic          parity_err;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          perr;
  } exp_t;
  exp_t q[$];

  sram_bank #(.DATA_W(DW), .ADDR_W(AW), .INIT_VAL('0)) dut (
    .clk        (clk),
    .rst        (rst),
    .soft_clear (soft_clear),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_be     (req_be),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef SRAM_PARITY_EN
    .inj_err    (inj_err),
    .parity_err (parity_err),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .init_busy  (init_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every response pops one expectation
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0 (no read outstanding)");
      end else begin
        e = q.pop_front();
        check("rsp_rdata", rsp_rdata, e.data);
`ifdef SRAM_PARITY_EN
        check("parity_err", parity_err, e.perr);
`endif
      end
    end
`ifdef SRAM_PARITY_EN
    else if (rst) check("parity_err_idle", parity_err, 0);
`endif
  end

  task automatic req(input bit we, input logic [3:0] be, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [DW-1:0] exp_d, input bit exp_p);
    req_valid = 1'b1;
    req_we    = we;
    req_be    = be;
    req_addr  = a;
    req_wdata = d;
    check("req_ready", req_ready, 1);
    if (!we) q.push_back('{exp_d, exp_p});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Counts busy cycles until RUN; optionally pulses soft_clear or rst at sweep cycle pulse_at
  task automatic wait_init(output int n, input int pulse_at, input bit use_rst);
    bit done = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!init_busy) begin
        done = 1'b1;
        break;
      end
      if (req_ready !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL ready_in_init: got %0b expected 0", req_ready);
      end
      n++;
      if (i == pulse_at) begin
        if (use_rst) begin
          rst = 1'b0;
          #1;
          check("rst_mid_busy", init_busy, 1);
          check("rst_mid_ready", req_ready, 0);
          check("rst_mid_rvalid", rsp_valid, 0);
          check("rst_mid_rdata", rsp_rdata, 0);
          @(negedge clk);
          rst = 1'b1;
          n = 1;
        end else begin
          soft_clear = 1'b1;
        end
      end else begin
        soft_clear = 1'b0;
      end
    end
    soft_clear = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL init_timeout: got init_busy stuck at 1 expected RUN within 200 cycles");
    end
  endtask

  initial begin
    int n;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_rvalid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_busy", init_busy, 1);
    rst = 1'b1;

    wait_init(n, -1, 1'b0);
    check("init_cycles", n, 16);

    for (int a = 0; a < 16; a++) req(1'b0, 4'h0, AW'(a), '0, 32'h0, 1'b0);

    req(1'b1, 4'hF, 4'd5, 32'hDEADBEEF, '0, 1'b0);
    req(1'b0, 4'h0, 4'd5, '0, 32'hDEADBEEF, 1'b0);
    req(1'b1, 4'b0101, 4'd5, 32'h11223344, '0, 1'b0);
    idle(1);
    req(1'b0, 4'h0, 4'd5, '0, 32'hDE22BE44, 1'b0);
    req(1'b1, 4'h0, 4'd5, 32'hFFFFFFFF, '0, 1'b0);
    req(1'b0, 4'h0, 4'd5, '0, 32'hDE22BE44, 1'b0);
    idle(2);
    check("rsp_hold_rdata", rsp_rdata, 32'hDE22BE44);
    check("rsp_idle_valid", rsp_valid, 0);

    req(1'b1, 4'hF, 4'd1, 32'hA1A1A1A1, '0, 1'b0);
    req(1'b1, 4'hF, 4'd2, 32'hB2B2B2B2, '0, 1'b0);
    req(1'b1, 4'hF, 4'd3, 32'hC3C3C3C3, '0, 1'b0);
    req(1'b0, 4'h0, 4'd1, '0, 32'hA1A1A1A1, 1'b0);
    req(1'b0, 4'h0, 4'd2, '0, 32'hB2B2B2B2, 1'b0);
    req(1'b1, 4'hF, 4'd7, 32'h77777777, '0, 1'b0);
    req(1'b0, 4'h0, 4'd3, '0, 32'hC3C3C3C3, 1'b0);
    req(1'b0, 4'h0, 4'd7, '0, 32'h77777777, 1'b0);
    idle(1);

    // Read accepted alongside soft_clear still responds; a second pulse mid-sweep is ignored
    soft_clear = 1'b1;
    req(1'b0, 4'h0, 4'd5, '0, 32'hDE22BE44, 1'b0);
    soft_clear = 1'b0;
    req_valid  = 1'b0;
    wait_init(n, 3, 1'b0);
    check("soft_clear_cycles", n, 16);
    req(1'b0, 4'h0, 4'd5, '0, 32'h0, 1'b0);
    req(1'b0, 4'h0, 4'd7, '0, 32'h0, 1'b0);
    idle(1);

    soft_clear = 1'b1;
    req(1'b1, 4'hF, 4'd3, 32'h5, '0, 1'b0);
    soft_clear = 1'b0;
    req_valid  = 1'b0;
    wait_init(n, 7, 1'b1);
    check("rst_restart_cycles", n, 16);
    req(1'b0, 4'h0, 4'd3, '0, 32'h0, 1'b0);
    idle(1);

`ifdef SRAM_PARITY_EN
    inj_err = 1'b1;
    req(1'b1, 4'hF, 4'd9, 32'hA5A5A5A5, '0, 1'b0);
    inj_err = 1'b0;
    req(1'b0, 4'h0, 4'd9, '0, 32'hA5A5A5A5, 1'b1);
    req(1'b1, 4'hF, 4'd9, 32'hA5A5A5A5, '0, 1'b0);
    req(1'b0, 4'h0, 4'd9, '0, 32'hA5A5A5A5, 1'b0);
    idle(1);
`endif

    idle(3);
    check("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000 time units");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
